// File: rtl/pipe_credit_ctrl.sv
// Credit-based flow controller for a fixed-latency, non-stallable datapath.
// Tracks in-flight validity and captures results into a first-word-fall-through output FIFO.
module pipe_credit_ctrl #(
    parameter int DW    = 16,
    parameter int L     = 4,
    parameter int DEPTH = 6,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    output logic          pipe_en,
    input  logic [DW-1:0] pipe_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_data,
    output logic [CW-1:0] credits,
    output logic          idle
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [L-1:0]  r_track;
    logic [DW-1:0] r_mem [DEPTH];
    logic [PW-1:0] r_wptr;
    logic [PW-1:0] r_rptr;
    logic [CW-1:0] r_count;
    logic [CW-1:0] r_credits;

    logic w_issue;
    logic w_pop;
    logic w_capture;
    logic w_empty;
    logic w_full;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    // in_ready uses only registered state plus rst, so it never loops back through out_ready.
    assign in_ready  = (r_credits != '0) & ~rst;
    assign w_issue   = in_valid & in_ready;
    assign pipe_en   = w_issue;
    assign w_empty   = (r_count == '0);
    assign w_full    = (r_count == CW'(DEPTH));
    assign out_valid = ~w_empty;
    assign w_pop     = out_valid & out_ready;
    assign w_capture = r_track[L-1];
    assign out_data  = w_empty ? '0 : r_mem[r_rptr];
    assign credits   = r_credits;
    assign idle      = (r_track == '0) & w_empty;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_track <= '0;
        end else begin
            r_track[0] <= w_issue;
            for (int i = 1; i < L; i++) begin
                r_track[i] <= r_track[i-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_capture) begin
            r_mem[r_wptr] <= pipe_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_capture) begin
                r_wptr <= ptr_inc(r_wptr);
            end
            if (w_pop) begin
                r_rptr <= ptr_inc(r_rptr);
            end
            case ({w_capture, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_credits <= CW'(DEPTH);
        end else begin
            case ({w_issue, w_pop})
                2'b10:   r_credits <= r_credits - CW'(1);
                2'b01:   r_credits <= r_credits + CW'(1);
                default: r_credits <= r_credits;
            endcase
        end
    end

    // A capture into a full FIFO means the credit accounting is broken.
    a_no_overflow: assert property (@(posedge clk) disable iff (rst)
        !(w_capture && w_full && !w_pop))
        else $error("pipe_credit_ctrl: capture into full fifo");

    a_credit_bound: assert property (@(posedge clk) disable iff (rst)
        r_credits <= CW'(DEPTH))
        else $error("pipe_credit_ctrl: credits above depth");

    a_credit_sum: assert property (@(posedge clk) disable iff (rst)
        (int'(r_credits) + int'(r_count) + $countones(r_track)) == DEPTH)
        else $error("pipe_credit_ctrl: credit accounting inconsistent");

endmodule
